// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selects, legal prescale
// ratios and small helpers used by both the RX and TX paths.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  typedef struct packed {
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
  } rx_cfg_t;

  // Unsupported ratios fall back to 8 so every mid-bit edge exists and a
  // frame always completes (with meaningless data).
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
      default:                              return PRESCALE_8;
    endcase
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: edge counter, three mid-bit samples and the
// registered 2-of-3 vote handed to the receive FSM.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic       run,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  output logic [5:0] edge_cnt,
  output logic       bit_done,
  output logic       sample_valid,
  output logic       sample_bit
);

  logic [5:0] half;
  logic       s_early;
  logic       s_mid;

  assign half     = prescale >> 1;
  assign bit_done = (edge_cnt == prescale - 6'd1);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      edge_cnt     <= '0;
      s_early      <= 1'b1;
      s_mid        <= 1'b1;
      sample_valid <= 1'b0;
      sample_bit   <= 1'b1;
    end else begin
      sample_valid <= 1'b0;

      if (!run || bit_done)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + 6'd1;

      if (edge_cnt == half - 6'd1)
        s_early <= RX_IN;
      if (edge_cnt == half)
        s_mid <= RX_IN;
      // Third sample is the live line; the vote is visible one cycle later.
      if (edge_cnt == half + 6'd1) begin
        sample_valid <= 1'b1;
        sample_bit   <= majority3(s_early, s_mid, RX_IN);
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start qualification, LSB-first deserialisation, optional
// parity and stop check, registered one-cycle result pulses.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge; config latched on exit
// START  | qualifying the start bit, a voted 1 is a glitch
// DATA   | shifting in width data bits, LSB first
// PARITY | comparing the parity bit, mismatch is remembered for the frame
// STOP   | stop-bit vote decides Data_valid / Par_err / Stop_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             RX_IN,
  input  logic [5:0]       Prescale,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [width-1:0] P_DATA,
  output logic             Data_valid,
  output logic             Par_err,
  output logic             Stop_err
);

  localparam int BCW = (width > 1) ? $clog2(width) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(width - 1);

  logic [2:0]       state;
  rx_cfg_t          cfg;
  logic [BCW-1:0]   bit_cnt;
  logic [width-1:0] shreg;
  logic             par_fail;
  logic             par_exp;
  logic             run;
  logic             abort;
  logic [5:0]       edge_cnt;
  logic             bit_done;
  logic             sample_valid;
  logic             sample_bit;

  uart_rx_sampler u_sampler (
    .CLK          (CLK),
    .Reset        (Reset),
    .run          (run),
    .RX_IN        (RX_IN),
    .prescale     (cfg.prescale),
    .edge_cnt     (edge_cnt),
    .bit_done     (bit_done),
    .sample_valid (sample_valid),
    .sample_bit   (sample_bit)
  );

  always_comb begin
    par_exp = (cfg.par_typ == PAR_ODD) ? ~^shreg : ^shreg;
  end

  // The sampler keeps counting only while a frame continues; leaving to IDLE
  // zeroes the edge counter so the next falling edge is edge 0.
  always_comb begin
    abort = (state != ST_IDLE) && (edge_cnt >= cfg.prescale);
    run   = 1'b1;
    case (state)
      ST_IDLE:  run = !RX_IN;
      ST_START: if (sample_valid && sample_bit) run = 1'b0;
      ST_STOP:  if (sample_valid) run = 1'b0;
      default:  ;
    endcase
    if (abort)
      run = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= ST_IDLE;
      cfg        <= '{prescale: PRESCALE_8, par_en: 1'b0, par_typ: PAR_EVEN};
      bit_cnt    <= '0;
      shreg      <= '0;
      par_fail   <= 1'b0;
      P_DATA     <= '0;
      Data_valid <= 1'b0;
      Par_err    <= 1'b0;
      Stop_err   <= 1'b0;
    end else begin
      Data_valid <= 1'b0;
      Par_err    <= 1'b0;
      Stop_err   <= 1'b0;

      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!RX_IN) begin
              cfg      <= '{prescale: legal_prescale(Prescale), par_en: PAR_EN, par_typ: PAR_TYP};
              bit_cnt  <= '0;
              par_fail <= 1'b0;
              state    <= ST_START;
            end
          end

          ST_START: begin
            if (sample_valid && sample_bit)
              state <= ST_IDLE;
            else if (bit_done) begin
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end

          ST_DATA: begin
            if (sample_valid)
              shreg <= {sample_bit, shreg[width-1:1]};
            if (bit_done) begin
              if (bit_cnt == LAST_BIT)
                state <= cfg.par_en ? ST_PARITY : ST_STOP;
              else
                bit_cnt <= bit_cnt + BCW'(1);
            end
          end

          ST_PARITY: begin
            if (sample_valid && (sample_bit != par_exp))
              par_fail <= 1'b1;
            if (bit_done)
              state <= ST_STOP;
          end

          ST_STOP: begin
            if (sample_valid) begin
              state <= ST_IDLE;
              if (!sample_bit)
                Stop_err <= 1'b1;
              else if (par_fail)
                Par_err <= 1'b1;
              else begin
                P_DATA     <= shreg;
                Data_valid <= 1'b1;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed frames against an event-queue model of the receiver's results;
// every cycle the pulses and P_DATA are compared with the model.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_valid;
  logic       Par_err;
  logic       Stop_err;

  uart_rx #(.width(8)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_valid (Data_valid),
    .Par_err    (Par_err),
    .Stop_err   (Stop_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // kind: 0 good word, 1 parity error, 2 stop error, 3 reset
  typedef struct {
    int         at;
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        ev_q[$];
  int         total = 0;
  int         bad = 0;
  bit         chk_on = 0;
  logic [7:0] model_pdata = 8'h00;
  int         n_dv = 0;
  int         n_pe = 0;
  int         n_se = 0;
  int         last_dv_at = -1;
  int         t0;
  int         t_dummy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    logic e_dv, e_pe, e_se;
    if (chk_on) begin
      e_dv = 1'b0;
      e_pe = 1'b0;
      e_se = 1'b0;
      while (ev_q.size() > 0 && ev_q[0].at <= cyc) begin
        if (ev_q[0].at < cyc)
          check("event_stale", ev_q[0].at, cyc);
        case (ev_q[0].kind)
          0: begin e_dv = 1'b1; model_pdata = ev_q[0].data; end
          1: e_pe = 1'b1;
          2: e_se = 1'b1;
          default: model_pdata = 8'h00;
        endcase
        void'(ev_q.pop_front());
      end
      check("Data_valid", Data_valid, e_dv);
      check("Par_err", Par_err, e_pe);
      check("Stop_err", Stop_err, e_se);
      check("P_DATA", P_DATA, model_pdata);
      if (Data_valid) begin n_dv++; last_dv_at = cyc; end
      if (Par_err) n_pe++;
      if (Stop_err) n_se++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // Drives one frame bit by bit. gbit flips the middle sample of that frame
  // bit; rst_bit pulses Reset at mid-bit of that frame bit and aborts.
  task automatic send_frame(input logic [5:0] p, input logic pen, input logic ptyp,
                            input logic [7:0] d, input bit par_flip, input logic stop_v,
                            input int gbit, input int rst_bit, output int ft0);
    logic bits[$];
    int   pi, n, kind;
    pi = int'(p);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((ptyp ? ~^d : ^d) ^ par_flip);
    bits.push_back(stop_v);
    n = bits.size();
    kind = !stop_v ? 2 : ((pen && par_flip) ? 1 : 0);
    ft0 = 0;
    for (int b = 0; b < n; b++) begin
      for (int e = 0; e < pi; e++) begin
        @(negedge CLK);
        if (b == 0 && e == 0) begin
          Prescale = p; PAR_EN = pen; PAR_TYP = ptyp;
          ft0 = cyc + 1;
        end
        if (b == 1 && e == 0) begin
          Prescale = ~p; PAR_EN = ~pen; PAR_TYP = ~ptyp;
        end
        if (b == n - 1 && e == 0)
          ev_q.push_back('{at: ft0 + (n - 1) * pi + pi / 2 + 2, kind: kind, data: d});
        if (b == rst_bit && e == pi / 2) begin
          Reset = 1'b1;
          RX_IN = 1'b1;
          ev_q.push_back('{at: cyc + 1, kind: 3, data: 8'h00});
          @(negedge CLK);
          Reset = 1'b0;
          return;
        end
        RX_IN = (b == gbit && e == pi / 2) ? ~bits[b] : bits[b];
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_P_DATA", P_DATA, 8'h00);
    check("reset_pulses", {Data_valid, Par_err, Stop_err}, 3'b000);
    Reset = 1'b0;
    chk_on = 1;
    idle(5);

    send_frame(6'd8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, -1, t0);
    idle(10);
    check("t1_word", P_DATA, 8'hA5);
    check("t1_latency", last_dv_at - t0, 78);
    check("t1_dv_count", n_dv, 1);

    send_frame(6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, -1, t_dummy);
    idle(20);
    check("t2_par_count", n_pe, 1);
    check("t2_dv_count", n_dv, 1);
    check("t2_word_held", P_DATA, 8'hA5);

    send_frame(6'd8, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, -1, -1, t_dummy);
    idle(40);
    check("t3_stop_count", n_se, 1);
    check("t3_other_counts", {n_dv[7:0], n_pe[7:0]}, 16'h0101);
    send_frame(6'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, -1, -1, t_dummy);
    idle(10);
    check("t3_next_word", P_DATA, 8'h81);

    @(negedge CLK);
    Prescale = 6'd16;
    RX_IN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RX_IN = 1'b1;
    idle(20);
    check("t4_glitch_no_dv", n_dv, 2);
    send_frame(6'd16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4, -1, t_dummy);
    idle(20);
    check("t4_vote_word", P_DATA, 8'h00);
    check("t4_dv_count", n_dv, 3);

    send_frame(6'd32, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, -1, -1, t_dummy);
    send_frame(6'd32, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, -1, -1, t_dummy);
    idle(40);
    check("t5_word", P_DATA, 8'hFF);
    check("t5_dv_count", n_dv, 5);

    send_frame(6'd16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1, 5, t_dummy);
    check("t6_reset_word", P_DATA, 8'h00);
    check("t6_reset_pulses", {Data_valid, Par_err, Stop_err}, 3'b000);
    idle(20);
    send_frame(6'd8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, -1, -1, t_dummy);
    idle(10);
    check("t6_word", P_DATA, 8'hC3);
    check("final_dv_count", n_dv, 6);
    check("final_err_counts", {n_pe[7:0], n_se[7:0]}, 16'h0101);
    check("events_drained", ev_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side counterpart of the UART TX path. Oversamples the serial line RX_IN at Prescale samples per bit, detects and qualifies the start bit, and majority-votes each bit at mid-bit. It deserializes a width-bit word LSB first, checks optional parity and the stop bit, then presents the word on P_DATA with a one-cycle Data_valid pulse or reports an error. It sits between the line (already synchronised to CLK externally) and the RX-side consumer.

## Interface
- width, 8, data bits per frame
- CLK  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- RX_IN  in  1  serial line, idle high, synchronous to CLK
- Prescale  in  6  oversampling ratio; legal values 8, 16, 32
- PAR_EN  in  1  1 = parity bit present after data
- PAR_TYP  in  1  0 = even, 1 = odd
- P_DATA  out  width  last good word, LSB = first received bit
- Data_valid  out  1  one-cycle pulse, P_DATA updated this cycle
- Par_err  out  1  one-cycle pulse, parity mismatch
- Stop_err  out  1  one-cycle pulse, stop bit sampled 0

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RX_IN==0 moves to START.
  - That cycle is edge 0 of the start bit.
  - Prescale, PAR_EN and PAR_TYP are latched here; changes mid-frame are ignored.
- Edge counter:
  - Runs 0..P-1 per bit and wraps to 0 with bit counter +1.
- Sampling:
  - RX_IN is sampled at edges P/2-1, P/2 and P/2+1.
  - The bit value is the 2-of-3 majority, decided at edge P/2+1.
- START:
  - Voted 1 = glitch: return to IDLE at edge P/2+1, no outputs.
  - Voted 0: go to DATA at edge P-1.
- DATA:
  - width bits, shifted in as {bit, shreg[width-1:1]}.
  - After bit width-1, edge P-1: go to PARITY if PAR_EN, else STOP.
- PARITY:
  - Expected bit = ^shreg for even, ~^shreg for odd.
  - A mismatch sets a sticky par_fail flag for the frame.
- STOP:
  - At the vote (edge P/2+1), the FSM returns to IDLE immediately so the next falling edge resynchronises.
  - Voted 0 → Stop_err pulse.
  - Voted 1 and par_fail → Par_err pulse.
  - Voted 1 and no par_fail → P_DATA <= shreg, Data_valid pulse.
  - Stop-bit failure takes priority; at most one of the three pulses is asserted per frame.
- On error, P_DATA holds its previous value.
- An illegal Prescale value gives undefined data, but the FSM must always return to IDLE within one frame.
- Reset:
  - All outputs go to 0, P_DATA to 0, and the FSM to IDLE.
  - A reset mid-frame aborts the frame with no pulses.

## Timing
- t0 = the cycle RX_IN==0 is first seen in IDLE.
- Frame length N = 1 + width + PAR_EN + 1 bits.
- The stop vote is registered at t0 + (N-1)·P + P/2 + 1.
- Data_valid, Par_err and Stop_err are high exactly in cycle t0 + (N-1)·P + P/2 + 2.
- Example: width=8, no parity, P=8 gives t0+78.
- Back-to-back frames:
  - A start bit beginning at the nominal end of the stop bit is detected.
  - Up to P/2-2 cycles of early start are tolerated.
- Outputs are registered; there is no combinational path from RX_IN.

## Structure
- Package uart_pkg:
  - FSM state encoding.
  - Parity type constants PAR_EVEN=0 and PAR_ODD=1.
  - Legal prescale constants.
  - Shared with the TX path.
- Sub-module uart_rx_sampler:
  - Holds the edge counter, the three-sample registers and the majority vote.
  - Outputs edge_cnt, bit_done (edge P-1) and sample_valid/sample_bit (edge P/2+1).
- The top level holds the FSM, bit counter, shift register, parity check and output registers.

## Test plan
- P=8, no parity, frame 0xA5 → P_DATA=0xA5, Data_valid single pulse at t0+78, Par_err=Stop_err=0.
- P=16, PAR_EN=1, even parity, data 0x3C with parity bit driven 1 → Par_err pulse, Data_valid=0, P_DATA unchanged from the previous word.
- P=8, data 0x0F, stop bit driven 0 → Stop_err pulse only; the next clean frame 0x81 is received correctly.
- P=16, RX_IN low for 2 cycles then high → no pulses, FSM back in IDLE by t0+9. Separately, one of the three samples flipped in data bit 3 of 0x00 → P_DATA=0x00.
- P=32, odd parity, frames 0x55 then 0xFF with no idle gap → two Data_valid pulses, P_DATA 0x55 then 0xFF.
- Reset asserted during data bit 4 → next cycle all outputs 0 and no pulses; a following frame 0xC3 is received correctly.
